// File: rtl/proc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | proc_pkg : shared constants for the 9-bit processor and its feeder   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package proc_pkg;

  localparam int n = 9;

  localparam logic [2:0] mv   = 3'b000;
  localparam logic [2:0] mvi  = 3'b001;
  localparam logic [2:0] add  = 3'b010;
  localparam logic [2:0] sub  = 3'b011;
  localparam logic [2:0] halt = 3'b111;

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_FETCH = 3'd1;
  localparam logic [2:0] c_ST_ISSUE = 3'd2;
  localparam logic [2:0] c_ST_IMM   = 3'd3;
  localparam logic [2:0] c_ST_WAIT  = 3'd4;
  localparam logic [2:0] c_ST_HALT  = 3'd5;

  function automatic logic [2:0] opcode(input logic [n-1:0] word);
    return word[n-1 -: 3];
  endfunction

endpackage
`default_nettype wire

// File: rtl/prog_feeder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prog_feeder_if : program load, processor handshake and status bundle |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface prog_feeder_if
  import proc_pkg::*;
#(
  parameter int AW = 5
);

  logic          Go;
  logic          WrEn;
  logic [AW-1:0] WrAddr;
  logic [n-1:0]  WrData;
  logic          Done;
  logic [n-1:0]  DIN;
  logic          Run;
  logic [AW-1:0] PC;
  logic          Halted;
  logic [7:0]    InstrCount;

  modport master (
    input  Go, WrEn, WrAddr, WrData, Done,
    output DIN, Run, PC, Halted, InstrCount
  );

  modport slave (
    output Go, WrEn, WrAddr, WrData, Done,
    input  DIN, Run, PC, Halted, InstrCount
  );

endinterface
`default_nettype wire

// File: rtl/prog_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prog_ram : program store, one write port, registered read, no reset  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module prog_ram
  import proc_pkg::*;
#(
  parameter int AW = 5,
  parameter int W  = n
) (
  input  logic          Clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [0:(2**AW)-1];

  always_ff @(posedge Clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule
`default_nettype wire

// File: rtl/prog_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prog_feeder : fetches program words and issues them to the processor |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module prog_feeder
  import proc_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic Clock,
  input  logic Reset,
  prog_feeder_if.master bus
);

  logic [2:0]    r_state;
  logic [AW-1:0] r_pc;
  logic [7:0]    r_count;
  logic          r_mvi;
  logic [n-1:0]  r_imm;

  logic [n-1:0]  w_rdata;
  logic [2:0]    w_op;
  logic [AW-1:0] w_raddr;
  logic          w_we;

  assign w_op    = opcode(w_rdata);
  // In ISSUE the RAM is pointed at the mvi immediate; wraps past the top word.
  assign w_raddr = (r_state == c_ST_ISSUE) ? r_pc + AW'(1) : r_pc;
  assign w_we    = bus.WrEn && ((r_state == c_ST_IDLE) || (r_state == c_ST_HALT));

  prog_ram #(.AW(AW), .W(n)) u_ram (
    .Clock   (Clock),
    .i_we    (w_we),
    .i_waddr (bus.WrAddr),
    .i_wdata (bus.WrData),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= c_ST_IDLE;
      r_pc    <= '0;
      r_count <= '0;
      r_mvi   <= 1'b0;
      r_imm   <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE, c_ST_HALT: begin
          if (bus.Go) begin
            r_pc    <= '0;
            r_count <= '0;
            r_state <= c_ST_FETCH;
          end
        end
        c_ST_FETCH: r_state <= c_ST_ISSUE;
        c_ST_ISSUE: begin
          if (w_op == halt) begin
            r_state <= c_ST_HALT;
          end else begin
            if (r_count != 8'hFF) r_count <= r_count + 8'd1;
            r_mvi   <= (w_op == mvi);
            r_state <= (w_op == mvi) ? c_ST_IMM : c_ST_WAIT;
          end
        end
        c_ST_IMM: begin
          r_imm <= w_rdata;
          if (bus.Done) begin
            r_pc    <= r_pc + AW'(2);
            r_state <= c_ST_FETCH;
          end else begin
            r_state <= c_ST_WAIT;
          end
        end
        c_ST_WAIT: begin
          if (bus.Done) begin
            r_pc    <= r_pc + (r_mvi ? AW'(2) : AW'(1));
            r_state <= c_ST_FETCH;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.DIN = '0;
    bus.Run = 1'b0;
    case (r_state)
      c_ST_ISSUE: begin
        bus.DIN = w_rdata;
        bus.Run = (w_op != halt);
      end
      c_ST_IMM:  bus.DIN = w_rdata;
      c_ST_WAIT: bus.DIN = r_mvi ? r_imm : '0;
      default:   bus.DIN = '0;
    endcase
  end

  assign bus.PC         = r_pc;
  assign bus.Halted     = (r_state == c_ST_HALT);
  assign bus.InstrCount = r_count;

endmodule
`default_nettype wire

// File: tb/tb_prog_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_prog_feeder : directed program runs against a small processor model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_prog_feeder;
  import proc_pkg::*;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  prog_feeder_if #(.AW(5)) bus ();

  prog_feeder #(.AW(5)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int n_vec = 0;
  int n_err = 0;
  int run_pulses = 0;
  bit wrapped = 0;
  logic [4:0] prev_pc = '0;
  int lat_ovr = 0;
  int cnt = 0;

  // Processor model: Done is raised for the whole cycle the instruction completes in.
  always @(negedge Clock) begin
    if (Reset) begin
      cnt = 0;
      bus.Done = 1'b0;
    end else if (bus.Run) begin
      case (bus.DIN[8:6])
        mv, mvi:  cnt = 1;
        add, sub: cnt = 3;
        default:  cnt = 0;
      endcase
      if (lat_ovr != 0) cnt = lat_ovr;
      bus.Done = 1'b0;
    end else if (cnt > 0) begin
      bus.Done = (cnt == 1);
      cnt = cnt - 1;
    end else begin
      bus.Done = 1'b0;
    end
  end

  always @(negedge Clock) begin
    if (bus.Run) run_pulses++;
    if (prev_pc == 5'd31 && bus.PC == 5'd0) wrapped = 1;
    prev_pc = bus.PC;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1; bus.Go = 1'b0; bus.WrEn = 1'b0; lat_ovr = 0;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [8:0] d);
    @(negedge Clock);
    bus.WrEn = 1'b1; bus.WrAddr = a; bus.WrData = d;
  endtask

  task automatic wr_end();
    @(negedge Clock);
    bus.WrEn = 1'b0;
  endtask

  task automatic pulse_go();
    @(negedge Clock);
    bus.Go = 1'b1;
    @(negedge Clock);
    bus.Go = 1'b0;
  endtask

  task automatic wait_run(input string tag, input int bound);
    bit ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge Clock);
      if (bus.Run) begin ok = 1; break; end
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_halt(input string tag, input int bound);
    bit ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge Clock);
      if (bus.Halted) begin ok = 1; break; end
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    time t0;
    bit ok;
    bus.Go = 1'b0; bus.WrEn = 1'b0; bus.WrAddr = '0; bus.WrData = '0;

    // Reset state
    do_reset();
    @(negedge Clock);
    check("rst_run", bus.Run, 0);
    check("rst_din", bus.DIN, 0);
    check("rst_pc", bus.PC, 0);
    check("rst_halted", bus.Halted, 0);
    check("rst_count", bus.InstrCount, 0);

    // mvi R0,#5 ; halt
    wr(0, 9'h040); wr(1, 9'd5); wr(2, 9'h1C0); wr_end();
    run_pulses = 0;
    pulse_go();
    wait_run("t1_run", 10);
    check("t1_din_instr", bus.DIN, 9'h040);
    @(negedge Clock);
    check("t1_din_imm", bus.DIN, 9'd5);
    check("t1_run_low", bus.Run, 0);
    wait_halt("t1_halt", 20);
    check("t1_count", bus.InstrCount, 1);
    check("t1_pc", bus.PC, 2);
    check("t1_pulses", run_pulses, 1);

    // add R0,R1 ; halt, then add ; sub ; halt for the Run period
    do_reset();
    wr(0, 9'h081); wr(1, 9'h1C0); wr_end();
    pulse_go();
    wait_run("t2_run", 10);
    @(negedge Clock);
    check("t2_din_wait", bus.DIN, 0);
    wait_halt("t2_halt", 20);
    check("t2_pc", bus.PC, 1);
    check("t2_count", bus.InstrCount, 1);
    wr(1, 9'h0C2); wr(2, 9'h1C0); wr_end();
    pulse_go();
    wait_run("t2_run_a", 10);
    t0 = $time;
    wait_run("t2_run_b", 10);
    check("t2_period", 32'(($time - t0) / 10), 5);
    wait_halt("t2_halt2", 20);
    check("t2_pc2", bus.PC, 2);
    check("t2_count2", bus.InstrCount, 2);

    // mvi at 31 takes its immediate from address 0
    do_reset();
    wr(0, 9'h0AA);
    for (int a = 1; a < 31; a++) wr(5'(a), 9'h000);
    wr(31, 9'h040); wr_end();
    pulse_go();
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clock);
      if (bus.Run && bus.DIN == 9'h040) begin ok = 1; break; end
    end
    check("t3_mvi_seen", {31'd0, ok}, 1);
    @(negedge Clock);
    check("t3_imm_wrap", bus.DIN, 9'h0AA);
    check("t3_count", bus.InstrCount, 32);
    @(negedge Clock);
    check("t3_pc", bus.PC, 1);

    // 32 mv words, no halt: count saturates, PC wraps
    do_reset();
    for (int a = 0; a < 32; a++) wr(5'(a), 9'h000);
    wr_end();
    run_pulses = 0;
    wrapped = 0;
    pulse_go();
    ok = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge Clock);
      if (run_pulses >= 300) begin ok = 1; break; end
    end
    check("t4_300_runs", {31'd0, ok}, 1);
    check("t4_sat", bus.InstrCount, 255);
    check("t4_wrap", {31'd0, wrapped}, 1);

    // WrEn during ISSUE/WAIT is ignored
    do_reset();
    wr(0, 9'h081); wr(1, 9'h000); wr(2, 9'h000); wr(3, 9'h1C0); wr_end();
    pulse_go();
    wait_run("t5_run", 10);
    bus.WrEn = 1'b1; bus.WrAddr = 5'd3; bus.WrData = 9'h000;
    @(negedge Clock);
    bus.WrEn = 1'b0;
    wait_halt("t5_halt", 100);
    check("t5_pc", bus.PC, 3);
    check("t5_count", bus.InstrCount, 3);

    // Reset during IMM aborts; Go restarts at 0
    do_reset();
    wr(0, 9'h000); wr(1, 9'h048); wr(2, 9'h007); wr(3, 9'h1C0); wr_end();
    pulse_go();
    wait_run("t6_run_mv", 10);
    wait_run("t6_run_mvi", 10);
    check("t6_din_mvi", bus.DIN, 9'h048);
    @(negedge Clock);
    check("t6_imm", bus.DIN, 9'h007);
    Reset = 1'b1;
    @(negedge Clock);
    check("t6_rst_run", bus.Run, 0);
    check("t6_rst_din", bus.DIN, 0);
    check("t6_rst_pc", bus.PC, 0);
    check("t6_rst_count", bus.InstrCount, 0);
    Reset = 1'b0;
    pulse_go();
    wait_run("t6_rerun", 10);
    check("t6_rerun_din", bus.DIN, 9'h000);
    wait_halt("t6_halt", 30);
    check("t6_pc_halt", bus.PC, 3);

    // mvi whose Done comes late: immediate held on DIN in WAIT
    do_reset();
    wr(0, 9'h040); wr(1, 9'h123); wr(2, 9'h1C0); wr_end();
    lat_ovr = 2;
    pulse_go();
    wait_run("t7_run", 10);
    @(negedge Clock);
    check("t7_imm", bus.DIN, 9'h123);
    @(negedge Clock);
    check("t7_wait_hold", bus.DIN, 9'h123);
    wait_halt("t7_halt", 20);
    check("t7_pc", bus.PC, 2);
    lat_ovr = 0;

    // Write and Go together in IDLE: first fetch sees the new word
    do_reset();
    run_pulses = 0;
    @(negedge Clock);
    bus.WrEn = 1'b1; bus.WrAddr = 5'd0; bus.WrData = 9'h1C0; bus.Go = 1'b1;
    @(negedge Clock);
    bus.WrEn = 1'b0; bus.Go = 1'b0;
    wait_halt("t8_halt", 10);
    check("t8_pc", bus.PC, 0);
    check("t8_count", bus.InstrCount, 0);
    check("t8_pulses", run_pulses, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
